uart_rx_loader: RTL and testbench

//  Sequences the byte stream from the UART receiver into 32-bit memory writes (boot/program loader).

---
 rtl/uart_rx_loader.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_loader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_loader.sv
// uart_rx_loader: turns a framed UART byte stream into 32-bit memory writes.
// Frame: SYNC, ADDR[31:0] LE, LEN[15:0] LE, LEN payload bytes, XOR checksum.
// Optional feature macro: UART_LOADER_TIMEOUT_EN (inter-byte idle timeout).
`timescale 1ns/1ps
module uart_rx_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_cause
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_WRITE, S_CHECK
  } state_t;

  state_t      state_reg, state_next;
  logic        buf_full_reg;
  logic [7:0]  buf_data_reg;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic [15:0] len_reg, len_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [7:0]  csum_reg, csum_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic [1:0]  cause_reg, cause_next;
  logic        consume;
  logic        overrun;
  logic        timeout;

  // WRITE is the only state that leaves a buffered byte waiting, so it is
  // the only place an overrun can happen.
  assign consume = buf_full_reg && (state_reg != S_WRITE);
  assign overrun = rx_valid && buf_full_reg && !consume;

`ifdef UART_LOADER_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 1;
  logic [31:0] idle_cnt_reg;

  // Idle counter: cleared by every received byte, frozen while a write is pending.
  always_ff @(posedge clk) begin
    if (rst || rx_valid || state_reg == S_IDLE) begin
      idle_cnt_reg <= '0;
    end else if (state_reg != S_WRITE) begin
      idle_cnt_reg <= idle_cnt_reg + 32'd1;
    end
  end

  assign timeout = (state_reg != S_IDLE) && (state_reg != S_WRITE) &&
                   !rx_valid && (idle_cnt_reg == TIMEOUT_LAST);
`else
  // Without the timeout build a packet waits forever; the parameter is only
  // referenced so both builds accept the same parameter set.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // One-entry receive buffer; an overrun abandons both the old and the new byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full_reg <= 1'b0;
      buf_data_reg <= '0;
    end else if (overrun) begin
      buf_full_reg <= 1'b0;
    end else if (rx_valid) begin
      buf_full_reg <= 1'b1;
      buf_data_reg <= rx_data;
    end else if (consume) begin
      buf_full_reg <= 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      csum_reg  <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      cause_reg <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wstrb_reg <= wstrb_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      csum_reg  <= csum_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      cause_reg <= cause_next;
    end
  end

  // Frame parser: next state, assembled word and status pulses.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wstrb_next = wstrb_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    csum_next  = csum_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    cause_next = cause_reg;
    if (overrun) begin
      state_next = S_IDLE;
      err_next   = 1'b1;
      cause_next = 2'd2;
    end else if (timeout) begin
      state_next = S_IDLE;
      err_next   = 1'b1;
      cause_next = 2'd3;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (consume && buf_data_reg == SYNC_BYTE) begin
            state_next = S_ADDR;
            csum_next  = '0;
            cnt_next   = '0;
            cause_next = '0;
            wdata_next = '0;
            wstrb_next = '0;
          end
        end
        S_ADDR: begin
          if (consume) begin
            csum_next = csum_reg ^ buf_data_reg;
            addr_next = {buf_data_reg, addr_reg[31:8]};
            if (cnt_reg == 16'd3) begin
              addr_next[1:0] = 2'b00;
              cnt_next       = '0;
              state_next     = S_LEN;
            end else begin
              cnt_next = cnt_reg + 16'd1;
            end
          end
        end
        S_LEN: begin
          if (consume) begin
            csum_next = csum_reg ^ buf_data_reg;
            len_next  = {buf_data_reg, len_reg[15:8]};
            if (cnt_reg == 16'd1) begin
              cnt_next   = '0;
              state_next = ({buf_data_reg, len_reg[15:8]} == 16'd0) ? S_CHECK : S_DATA;
            end else begin
              cnt_next = 16'd1;
            end
          end
        end
        S_DATA: begin
          if (consume) begin
            csum_next = csum_reg ^ buf_data_reg;
            wdata_next[{cnt_reg[1:0], 3'b000} +: 8] = buf_data_reg;
            wstrb_next[cnt_reg[1:0]] = 1'b1;
            cnt_next = cnt_reg + 16'd1;
            if (cnt_reg[1:0] == 2'd3 || (cnt_reg + 16'd1) == len_reg) begin
              state_next = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            addr_next  = addr_reg + 32'd4;
            wdata_next = '0;
            wstrb_next = '0;
            state_next = (cnt_reg == len_reg) ? S_CHECK : S_DATA;
          end
        end
        S_CHECK: begin
          if (consume) begin
            if (buf_data_reg == csum_reg) begin
              done_next = 1'b1;
            end else begin
              err_next   = 1'b1;
              cause_next = 2'd1;
            end
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_wstrb = wstrb_reg;
  assign mem_valid = (state_reg == S_WRITE);
  assign busy      = (state_reg != S_IDLE);
  assign done      = done_reg;
  assign err       = err_reg;
  assign err_cause = cause_reg;

endmodule

// File: tb/tb_uart_rx_loader.sv
// tb_uart_rx_loader: scoreboard bench for uart_rx_loader (expected writes queued
// at stimulus time, popped when the DUT completes a write handshake).
`timescale 1ns/1ps
module tb_uart_rx_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_valid;
  logic        mem_ready = 1'b1;
  logic        busy, done, err;
  logic [1:0]  err_cause;

  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [1:0]  last_cause = '0;
  logic [7:0]  run_xor = '0;
  logic [7:0]  pay [0:15];
  logic [67:0] exp_q [$];

  uart_rx_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .busy(busy), .done(done), .err(err), .err_cause(err_cause)
  );

  always #5 clk = ~clk;

  // Monitor: score write handshakes and status pulses on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_valid && mem_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL write_unexpected got addr=%h data=%h strb=%h required none",
                   mem_addr, mem_wdata, mem_wstrb);
        end else begin
          logic [67:0] e;
          e = exp_q.pop_front();
          if ({mem_addr, mem_wdata, mem_wstrb} !== e) begin
            bad++;
            $display("FAIL write got addr=%h data=%h strb=%h required addr=%h data=%h strb=%h",
                     mem_addr, mem_wdata, mem_wstrb, e[67:36], e[35:4], e[3:0]);
          end else begin
            $display("write addr=%h data=%h strb=%h", mem_addr, mem_wdata, mem_wstrb);
          end
        end
      end
      if (done) done_cnt++;
      if (err) begin
        err_cnt++;
        last_cause = err_cause;
        $display("err pulse cause=%0d", err_cause);
      end
      if (done || err) begin
        total++;
        if (done && err) begin
          bad++;
          $display("FAIL done_err_exclusive got done=%b err=%b required not both", done, err);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got time=%0t required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    run_xor  = run_xor ^ b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_header(input logic [31:0] a, input logic [15:0] n);
    send_byte(8'hA5);
    run_xor = '0;
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [15:0] n, input logic flip);
    send_header(a, n);
    for (int i = 0; i < int'(n); i++) send_byte(pay[i]);
    send_byte(run_xor ^ (flip ? 8'hFF : 8'h00));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    total++;
    if ({mem_valid, busy, done, err, err_cause} !== 6'b0) begin
      bad++;
      $display("FAIL reset_status got valid=%b busy=%b done=%b err=%b cause=%0d required all 0",
               mem_valid, busy, done, err, err_cause);
    end
    total++;
    if ({mem_addr, mem_wdata, mem_wstrb} !== 68'b0) begin
      bad++;
      $display("FAIL reset_bus got addr=%h data=%h strb=%h required 0", mem_addr, mem_wdata, mem_wstrb);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_two_words();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 8; i++) pay[i] = 8'(8'h11 * (i + 1));
    exp_q.push_back({32'h0000_1000, 32'h4433_2211, 4'hF});
    exp_q.push_back({32'h0000_1004, 32'h8877_6655, 4'hF});
    send_frame(32'h0000_1000, 16'd8, 1'b0);
    repeat (20) @(posedge clk); #1;
    total++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      bad++;
      $display("FAIL two_words_status got done=%0d err=%0d required done=1 err=0", done_cnt - d0, err_cnt - e0);
    end
    total++;
    if (err_cause !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL two_words_idle got cause=%0d busy=%b required 0 0", err_cause, busy);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL two_words_writes got pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_partial_word();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) pay[i] = 8'(i + 1);
    exp_q.push_back({32'h0000_2000, 32'h0403_0201, 4'hF});
    exp_q.push_back({32'h0000_2004, 32'h0000_0005, 4'h1});
    send_frame(32'h0000_2000, 16'd5, 1'b0);
    repeat (20) @(posedge clk); #1;
    total++;
    if (done_cnt - d0 !== 1 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL partial_word got done=%0d pending=%0d required done=1 pending=0", done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_bad_checksum();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
    exp_q.push_back({32'h0000_5000, 32'hEFBE_ADDE, 4'hF});
    send_frame(32'h0000_5002, 16'd4, 1'b1);
    repeat (20) @(posedge clk); #1;
    total++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1 || last_cause !== 2'd1) begin
      bad++;
      $display("FAIL bad_checksum got done=%0d err=%0d cause=%0d required 0 1 1", done_cnt - d0, err_cnt - e0, last_cause);
    end
    total++;
    if (err_cause !== 2'd1 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL bad_checksum_hold got cause=%0d pending=%0d required 1 0", err_cause, exp_q.size());
    end
  endtask

  task automatic test_latency();
    int d0;
    d0 = done_cnt;
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC; pay[3] = 8'hDD;
    exp_q.push_back({32'h0000_4000, 32'hDDCC_BBAA, 4'hF});
    send_header(32'h0000_4000, 16'd4);
    for (int i = 0; i < 3; i++) send_byte(pay[i]);
    @(posedge clk); #1;
    rx_data = pay[3]; rx_valid = 1'b1; run_xor = run_xor ^ pay[3];
    @(posedge clk); #1;
    rx_valid = 1'b0;
    total++;
    if (mem_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_edge1 got mem_valid=%b required 0", mem_valid);
    end
    @(posedge clk); #1;
    total++;
    if (mem_valid !== 1'b1) begin
      bad++;
      $display("FAIL latency_edge2 got mem_valid=%b required 1", mem_valid);
    end
    send_byte(run_xor);
    repeat (20) @(posedge clk); #1;
    total++;
    if (done_cnt - d0 !== 1 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL latency_frame got done=%0d pending=%0d required 1 0", done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_overrun();
    int e0;
    e0 = err_cnt;
    mem_ready = 1'b0;
    send_header(32'h0000_3000, 16'd8);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h30 + i));
    send_byte(8'h34);
    send_byte(8'h35);
    repeat (10) @(posedge clk); #1;
    total++;
    if (err_cnt - e0 !== 1 || last_cause !== 2'd2) begin
      bad++;
      $display("FAIL overrun_err got err=%0d cause=%0d required 1 2", err_cnt - e0, last_cause);
    end
    total++;
    if (mem_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL overrun_idle got valid=%b busy=%b pending=%0d required 0 0 0", mem_valid, busy, exp_q.size());
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_garbage_len0();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    send_frame(32'h0000_6000, 16'd0, 1'b0);
    repeat (20) @(posedge clk); #1;
    total++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0 || err_cause !== 2'd0) begin
      bad++;
      $display("FAIL garbage_len0 got done=%0d err=%0d cause=%0d required 1 0 0", done_cnt - d0, err_cnt - e0, err_cause);
    end
  endtask

  task automatic test_stall();
    int e0;
    e0 = err_cnt;
    send_header(32'h0000_8000, 16'd4);
    repeat (100) @(posedge clk); #1;
`ifdef UART_LOADER_TIMEOUT_EN
    total++;
    if (err_cnt - e0 !== 1 || last_cause !== 2'd3 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout got err=%0d cause=%0d busy=%b required 1 3 0", err_cnt - e0, last_cause, busy);
    end
`else
    total++;
    if (busy !== 1'b1 || err_cnt - e0 !== 0) begin
      bad++;
      $display("FAIL stall_wait got busy=%b err=%0d required 1 0", busy, err_cnt - e0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL stall_reset got busy=%b required 0", busy);
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    mem_ready = 1'b0;
    send_header(32'h0000_7000, 16'd4);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h70 + i));
    repeat (100) @(posedge clk); #1;
    total++;
    if (mem_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL write_hold got valid=%b busy=%b required 1 1", mem_valid, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (mem_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_write got valid=%b busy=%b required 0 0", mem_valid, busy);
    end
    rst = 1'b0;
    mem_ready = 1'b1;
    repeat (5) @(posedge clk); #1;
    total++;
    if (exp_q.size() !== 0 || mem_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_write_after got pending=%0d valid=%b required 0 0", exp_q.size(), mem_valid);
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_partial_word();
    test_bad_checksum();
    test_latency();
    test_overrun();
    test_garbage_len0();
    test_stall();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
